// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter that lets N_REQ clients take turns writing one shared WIDTH-bit register.
// Each won grant loads the owner's data and returns a one-cycle acknowledge.
module reg_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int OWN_W = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       q,
    output logic                   q_valid,
    output logic [OWN_W-1:0]       owner,
    output logic                   busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    // First set request bit at or after position p, wrapping modulo N_REQ.
    function automatic logic [OWN_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [OWN_W-1:0] p);
        logic [OWN_W-1:0] pick;
        logic [OWN_W:0]   sum;
        logic [OWN_W-1:0] idx;
        pick = p;
        // Scan downward so the position closest to p is the last (winning) assignment.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum  = {1'b0, p} + (OWN_W + 1)'(k);
            idx  = (sum >= (OWN_W + 1)'(N_REQ)) ? OWN_W'(sum - (OWN_W + 1)'(N_REQ))
                                                 : OWN_W'(sum);
            pick = r[idx] ? idx : pick;
        end
        return pick;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [OWN_W-1:0] i);
        logic [N_REQ-1:0] oh;
        oh    = {N_REQ{1'b0}};
        oh[i] = 1'b1;
        return oh;
    endfunction

    state_t             state_r;
    logic [OWN_W-1:0]   ptr_r;
    logic [OWN_W-1:0]   owner_r;
    logic [N_REQ-1:0]   gnt_r;
    logic [N_REQ-1:0]   ack_r;
    logic [WIDTH-1:0]   q_r;
    logic               q_valid_r;
    logic               busy_r;

    logic [OWN_W-1:0]   win_s;
    logic               any_req_s;
    logic               owner_req_s;
    logic [WIDTH-1:0]   owner_data_s;
    logic [OWN_W-1:0]   ptr_next_s;

    // Arbitration decode and owner data selection; feeds registers only.
    always_comb begin
        win_s        = rr_pick(req, ptr_r);
        any_req_s    = |req;
        owner_req_s  = req[owner_r];
        owner_data_s = wdata[int'(owner_r) * WIDTH +: WIDTH];
        ptr_next_s   = (owner_r == OWN_W'(N_REQ - 1)) ? {OWN_W{1'b0}}
                                                      : owner_r + OWN_W'(32'd1);
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            ptr_r     <= {OWN_W{1'b0}};
            owner_r   <= {OWN_W{1'b0}};
            gnt_r     <= {N_REQ{1'b0}};
            ack_r     <= {N_REQ{1'b0}};
            q_r       <= {WIDTH{1'b0}};
            q_valid_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ack_r <= {N_REQ{1'b0}};
                    if (any_req_s) begin
                        owner_r <= win_s;
                        gnt_r   <= onehot(win_s);
                        busy_r  <= 1'b1;
                        state_r <= ST_GRANT;
                    end else begin
                        gnt_r   <= {N_REQ{1'b0}};
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    gnt_r <= {N_REQ{1'b0}};
                    if (owner_req_s) begin
                        q_r       <= owner_data_s;
                        q_valid_r <= 1'b1;
                        ack_r     <= onehot(owner_r);
                        state_r   <= ST_ACK;
                    end else begin
                        // Withdrawn request: no load and the pointer stays put.
                        ack_r   <= {N_REQ{1'b0}};
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACK: begin
                    gnt_r   <= {N_REQ{1'b0}};
                    ack_r   <= {N_REQ{1'b0}};
                    busy_r  <= 1'b0;
                    ptr_r   <= ptr_next_s;
                    state_r <= ST_IDLE;
                end
                default: begin
                    gnt_r   <= {N_REQ{1'b0}};
                    ack_r   <= {N_REQ{1'b0}};
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt     = gnt_r;
    assign ack     = ack_r;
    assign q       = q_r;
    assign q_valid = q_valid_r;
    assign owner   = owner_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Scoreboard bench for reg_share_arbiter: a round-robin model predicts grants and loads,
// and a negedge monitor compares whatever the DUT presents against the queued predictions.
module tb_reg_share_arbiter;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [7:0]  q;
    logic        q_valid;
    logic [1:0]  owner;
    logic        busy;

    reg_share_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .wdata(wdata),
        .gnt(gnt), .ack(ack), .q(q), .q_valid(q_valid), .owner(owner), .busy(busy)
    );

    typedef struct {
        int         own;
        logic [7:0] dat;
    } exp_t;

    int         n_vec = 0;
    int         n_err = 0;
    int         gntq[$];
    exp_t       ackq[$];
    int         mptr = 0;
    logic [7:0] mdl_q = 8'h00;
    logic       mdl_qv = 1'b0;
    int         mon_g;
    exp_t       mon_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Round-robin reference: first requester at or after the pointer, modulo 4.
    function automatic int rr_win(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // Monitor: consumes predictions whenever the DUT shows a grant or an acknowledge.
    always @(negedge clk) begin
        if (!reset_n) begin
            mdl_q  = 8'h00;
            mdl_qv = 1'b0;
            chk("rst_q", q, 0);
            chk("rst_q_valid", q_valid, 0);
            chk("rst_gnt", gnt, 0);
            chk("rst_ack", ack, 0);
            chk("rst_busy", busy, 0);
        end else begin
            if (gnt != 4'b0000) begin
                if (gntq.size() == 0) chk("gnt_unexpected", gnt, 0);
                else begin
                    mon_g = gntq.pop_front();
                    chk("gnt_order", gnt, 32'd1 << mon_g);
                end
            end
            if (ack != 4'b0000) begin
                if (ackq.size() == 0) chk("ack_unexpected", ack, 0);
                else begin
                    mon_e = ackq.pop_front();
                    chk("ack_onehot", ack, 32'd1 << mon_e.own);
                    chk("ack_owner", owner, mon_e.own);
                    mdl_q  = mon_e.dat;
                    mdl_qv = 1'b1;
                end
            end
            chk("q", q, mdl_q);
            chk("q_valid", q_valid, mdl_qv);
        end
    end

    // One arbitration round starting from IDLE; wd withdraws the winner during GRANT.
    task automatic serve(input logic [3:0] r, input logic [31:0] d, input bit wd);
        int w;
        w     = rr_win(r, mptr);
        req   = r;
        wdata = d;
        gntq.push_back(w);
        if (!wd) ackq.push_back('{w, d[w*8 +: 8]});
        @(negedge clk);
        chk("gnt_latency", gnt, 32'd1 << w);
        chk("busy_grant", busy, 1);
        chk("ack_in_grant", ack, 0);
        if (wd) req[w] = 1'b0;
        @(negedge clk);
        if (wd) begin
            chk("gnt_after_withdraw", gnt, 0);
            chk("ack_after_withdraw", ack, 0);
            chk("busy_after_withdraw", busy, 0);
        end else begin
            chk("gnt_in_ack", gnt, 0);
            chk("busy_ack", busy, 1);
            mptr = (w + 1) % 4;
            @(negedge clk);
            chk("busy_idle", busy, 0);
            chk("ack_idle", ack, 0);
        end
        chk("owner", owner, w);
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        mptr    = 0;
        gntq.delete();
        ackq.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [3:0]  rr;
        logic [31:0] rd;
        reset_n = 1'b0;
        req     = 4'b1111;
        wdata   = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        chk("rst_owner", owner, 0);
        // Release mid-cycle: nothing may move before the next rising edge.
        reset_n = 1'b1;
        #1;
        chk("release_gnt", gnt, 0);
        chk("release_busy", busy, 0);
        chk("release_q_valid", q_valid, 0);

        serve(4'b0100, 32'h00A5_0000, 1'b0);

        do_reset();
        repeat (4) serve(4'b1111, 32'h4332_2110, 1'b0);
        serve(4'b1111, 32'h4332_2110, 1'b0);
        repeat (3) serve(4'b1111, 32'h4332_2110, 1'b0);
        serve(4'b0010, 32'h4332_2110, 1'b1);
        chk("q_after_withdraw", q, 32'h43);
        serve(4'b0011, 32'h4332_2110, 1'b0);
        serve(4'b0010, 32'h0000_5500, 1'b0);
        serve(4'b0011, 32'h0000_6677, 1'b0);

        // Reset during ACK of a write of 8'hFF aborts everything.
        req   = 4'b1000;
        wdata = 32'hFF00_0000;
        gntq.push_back(rr_win(4'b1000, mptr));
        ackq.push_back('{3, 8'hFF});
        @(negedge clk);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        mptr    = 0;
        gntq.delete();
        ackq.delete();
        #1;
        chk("abort_ack", ack, 0);
        chk("abort_q", q, 0);
        chk("abort_q_valid", q_valid, 0);
        chk("abort_busy", busy, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("abort_release_gnt", gnt, 0);
        serve(4'b1000, 32'h5A00_0000, 1'b0);

        for (int i = 0; i < 60; i++) begin
            rr = 4'($urandom_range(1, 15));
            rd = $urandom;
            serve(rr, rd, ($urandom_range(0, 7) == 0));
        end

        req = 4'b0000;
        repeat (4) @(negedge clk);
        chk("gnt_queue_drained", gntq.size(), 0);
        chk("ack_queue_drained", ackq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
